// File: rtl/delta_step_gen.sv
// Step generator: walks cur_x/cur_y toward a target in clamped increments, handing each
// delta to a downstream multiply stage and committing it once that stage reports ready.
module delta_step_gen #(
    parameter int unsigned STEP_MAX = 64,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic signed [13:0] load_x,
    input  logic signed [13:0] load_y,
    input  logic               start,
    input  logic signed [13:0] target_x,
    input  logic signed [13:0] target_y,
    input  logic               mm_ready,
    output logic signed [13:0] dx,
    output logic signed [13:0] dy,
    output logic               mm_enable,
    output logic               mm_reset,
    output logic signed [13:0] cur_x,
    output logic signed [13:0] cur_y,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    typedef enum logic [2:0] {StIdle, StCalc, StIssue, StCommit, StFlush} state_e;

    localparam logic signed [14:0] StepPos  = 15'(STEP_MAX);
    localparam logic signed [14:0] StepNeg  = -StepPos;
    localparam logic [15:0]        WaitLast = 16'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic signed [13:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic signed [13:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic signed [13:0] dx_q, dx_d, dy_q, dy_d;
    logic [15:0]        wait_q, wait_d;
    logic               done_q, done_d, fault_q, fault_d;
    logic signed [14:0] ex, ey;

    function automatic logic signed [13:0] clamp_step(input logic signed [14:0] e);
        logic signed [14:0] r;
        if (e > StepPos)      r = StepPos;
        else if (e < StepNeg) r = StepNeg;
        else                  r = e;
        return r[13:0];
    endfunction

    // 15-bit error: the difference of two 14-bit values cannot overflow.
    assign ex = {tgt_x_q[13], tgt_x_q} - {cur_x_q[13], cur_x_q};
    assign ey = {tgt_y_q[13], tgt_y_q} - {cur_y_q[13], cur_y_q};

    always_comb begin
        state_d = state_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    cur_x_d = load_x;
                    cur_y_d = load_y;
                end
                if (start) begin
                    tgt_x_d = target_x;
                    tgt_y_d = target_y;
                    fault_d = 1'b0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (ex == 15'sd0 && ey == 15'sd0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    dx_d    = clamp_step(ex);
                    dy_d    = clamp_step(ey);
                    wait_d  = 16'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Ready wins even in the final allowed cycle.
                if (mm_ready) begin
                    state_d = StCommit;
                end else if (wait_q == WaitLast) begin
                    fault_d = 1'b1;
                    state_d = StFlush;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            StCommit: begin
                cur_x_d = cur_x_q + dx_q;
                cur_y_d = cur_y_q + dy_q;
                state_d = StCalc;
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tgt_x_q <= '0;
            tgt_y_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_x_q <= tgt_x_d;
            tgt_y_q <= tgt_y_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Downstream reset follows our reset directly so it is asserted without waiting for a clock.
    assign mm_reset  = reset || (state_q == StCommit) || (state_q == StFlush);
    assign mm_enable = (state_q == StIssue);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign fault     = fault_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_delta_step_gen.sv
// Scoreboard bench for delta_step_gen: directed moves push expected events, a monitor
// checks each step issue, done pulse and fault rise against the queue.
module tb_delta_step_gen;

    typedef struct {
        int kind;  // 0 step (dx,dy), 1 done (cur), 2 fault (cur)
        int a;
        int b;
    } exp_t;

    logic               clk, reset, load, start, mm_ready;
    logic signed [13:0] load_x, load_y, target_x, target_y;
    logic signed [13:0] dx, dy, cur_x, cur_y;
    logic               mm_enable, mm_reset, busy, done, fault;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   auto_ready = 0;
    int   ready_lat = 1;

    delta_step_gen #(.STEP_MAX(64), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset), .load(load), .load_x(load_x), .load_y(load_y),
        .start(start), .target_x(target_x), .target_y(target_y), .mm_ready(mm_ready),
        .dx(dx), .dy(dy), .mm_enable(mm_enable), .mm_reset(mm_reset),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .done(done), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int a, input int b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic expect_evt(input int kind, input int a, input int b, output exp_t e);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected event: kind %0d values %0d,%0d, expected none", kind, a, b);
            e.kind = -1;
        end else begin
            e = sb.pop_front();
            check("event kind", kind, e.kind);
            check("event value a", a, e.a);
            check("event value b", b, e.b);
        end
    endtask

    // Monitor
    initial begin
        logic prev_en, prev_fault;
        int   exp_dx, exp_dy;
        exp_t e;
        prev_en = 1'b0;
        prev_fault = 1'b0;
        exp_dx = 0;
        exp_dy = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mm_enable && !prev_en) begin
                    expect_evt(0, int'(dx), int'(dy), e);
                    exp_dx = e.a;
                    exp_dy = e.b;
                end else if (mm_enable) begin
                    check("dx stable in issue", int'(dx), exp_dx);
                    check("dy stable in issue", int'(dy), exp_dy);
                end
                if (done) expect_evt(1, int'(cur_x), int'(cur_y), e);
                if (fault && !prev_fault) expect_evt(2, int'(cur_x), int'(cur_y), e);
            end
            prev_en = mm_enable;
            prev_fault = fault;
        end
    end

    // Downstream stand-in: ready in the ready_lat-th cycle of each enable window
    initial begin
        int en_cnt;
        en_cnt = 0;
        mm_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mm_enable && !reset) en_cnt++;
            else en_cnt = 0;
            mm_ready = (auto_ready != 0) && mm_enable && (en_cnt == ready_lat);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_move(input int tx, input int ty);
        @(negedge clk);
        target_x = 14'(tx);
        target_y = 14'(ty);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n_en, output int n_mmr);
        int n;
        n = 0;
        n_en = 0;
        n_mmr = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
            if (mm_enable) n_en++;
            if (mm_reset) n_mmr++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait idle: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic check_cur(input string name, input int x, input int y);
        check({name, " cur_x"}, int'(cur_x), x);
        check({name, " cur_y"}, int'(cur_y), y);
    endtask

    initial begin
        int n_en, n_mmr, k;
        reset = 1'b1;
        load = 1'b0;
        start = 1'b0;
        load_x = '0;
        load_y = '0;
        target_x = '0;
        target_y = '0;
        #1;
        check("reset dx", int'(dx), 0);
        check("reset dy", int'(dy), 0);
        check_cur("reset", 0, 0);
        check("reset mm_enable", int'(mm_enable), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset fault", int'(fault), 0);
        check("reset mm_reset", int'(mm_reset), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mm_reset after release", int'(mm_reset), 0);

        // Two-step move; load and start pulsed mid-move must be ignored
        auto_ready = 1;
        ready_lat = 6;
        push(0, 64, -30);
        push(0, 36, 0);
        push(1, 100, -30);
        start_move(100, -30);
        load = 1'b1;
        load_x = -5;
        load_y = 17;
        start = 1'b1;
        target_x = 0;
        target_y = 0;
        @(negedge clk);
        load = 1'b0;
        start = 1'b0;
        wait_idle(300, n_en, n_mmr);
        check_cur("two-step", 100, -30);
        check("two-step fault", int'(fault), 0);

        // Zero-length move: done two cycles after start, no issue
        @(negedge clk);
        load = 1'b1;
        load_x = 500;
        load_y = 500;
        @(negedge clk);
        load = 1'b0;
        check_cur("load", 500, 500);
        push(1, 500, 500);
        target_x = 500;
        target_y = 500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero move done at +1", int'(done), 0);
        check("zero move busy at +1", int'(busy), 1);
        @(negedge clk);
        check("zero move done at +2", int'(done), 1);
        check("zero move busy at +2", int'(busy), 0);

        // Load and start together: move begins from the loaded point
        @(negedge clk);
        load = 1'b1;
        load_x = 7;
        load_y = -3;
        start = 1'b1;
        target_x = 27;
        target_y = -3;
        push(0, 20, 0);
        push(1, 27, -3);
        @(negedge clk);
        load = 1'b0;
        start = 1'b0;
        wait_idle(100, n_en, n_mmr);
        check_cur("load+start", 27, -3);

        // Full-range diagonal: 256 clamped steps, last one 63
        @(negedge clk);
        load = 1'b1;
        load_x = -8192;
        load_y = 8191;
        @(negedge clk);
        load = 1'b0;
        ready_lat = 1;
        for (int i = 0; i < 255; i++) push(0, 64, -64);
        push(0, 63, -63);
        push(1, 8191, -8192);
        start_move(8191, -8192);
        wait_idle(5000, n_en, n_mmr);
        check_cur("full range", 8191, -8192);

        // Reset during issue
        auto_ready = 0;
        push(0, -64, 64);
        start_move(0, 0);
        k = 0;
        while (!mm_enable && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("reached issue before reset", int'(mm_enable), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset dx", int'(dx), 0);
        check("mid reset dy", int'(dy), 0);
        check_cur("mid reset", 0, 0);
        check("mid reset mm_enable", int'(mm_enable), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset mm_reset", int'(mm_reset), 1);
        @(negedge clk);
        reset = 1'b0;
        auto_ready = 1;
        ready_lat = 3;
        push(0, 10, 5);
        push(1, 10, 5);
        start_move(10, 5);
        wait_idle(100, n_en, n_mmr);
        check_cur("after reset move", 10, 5);

        // Timeout: ready never comes
        auto_ready = 0;
        push(0, -10, -5);
        push(2, 10, 5);
        start_move(0, 0);
        wait_idle(100, n_en, n_mmr);
        check("timeout issue cycles", n_en, 10);
        check("timeout mm_reset pulses", n_mmr, 1);
        check("timeout fault", int'(fault), 1);
        check("timeout busy", int'(busy), 0);
        check_cur("timeout", 10, 5);
        @(negedge clk);
        check("fault sticky", int'(fault), 1);

        // Ready in the last allowed cycle commits; new start clears fault
        auto_ready = 1;
        ready_lat = 10;
        push(0, -10, -5);
        push(1, 0, 0);
        start_move(0, 0);
        check("fault cleared by start", int'(fault), 0);
        wait_idle(100, n_en, n_mmr);
        check("edge ready fault", int'(fault), 0);
        check_cur("edge ready", 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
